himem_ctrl_m: RTL
=================

Name: himem_ctrl_m

Overview:
- Parametrised 65816 high-memory controller; successor to the first-generation fixed 512K HIMEM decoder.
- Sits between the CPU socket and the host BBC bus.
- Latches the bank byte, decodes on-board RAM accesses and forces dummy host cycles for them.
- Adds a CPU-writable config register, native-mode low-RAM shadowing and a programmable RDY wait-state generator, all sampled on the host 8 MHz clock.

Parameters:
RAM_ABITS, 19, on-board RAM address width; RAM bank pins = RAM_ABITS-16 (legal 17..21).
HIMEM_MATCH, 2'b11, value of bank[7:6] that selects on-board RAM.
CFG_ADDR, 16'hFCF0, bank-0 address of the config register.
SHADOW_BANK, 8'h40, RAM bank used when shadowing bank-0 0x0000-0x7FFF.

Ports:
bbc_ck8  input  1  host 8 MHz clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
bbc_ck2_phi0  input  1  host 2 MHz phase clock, synchronous to bbc_ck8; high = PHI2.
cpu_e  input  1  65816 emulation flag.
vda  input  1  valid data address.
vpa  input  1  valid program address.
rnw  input  1  CPU read/not-write.
addr  input  16  CPU address.
cpu_d_in  input  8  CPU data bus: bank byte in PHI1, write data in PHI2.
ram_ceb  output  1  on-board RAM chip enable, active low.
ram_bank  output  RAM_ABITS-16  RAM address bits 16 and up.
bbc_rnw  output  1  host read/not-write, forced high on on-board accesses.
dummy_access  output  1  current cycle targets on-board RAM.
rdy_lo  output  1  1 = pull CPU RDY low (open-drain enable).
cfg_rd  output  1  current cycle reads the config register.
cfg_rdata  output  8  config register read value.

Behaviour:
- Edge detect: ph0_q <= bbc_ck2_phi0 every edge.
  - rise = phi0 & !ph0_q.
  - fall = !phi0 & ph0_q.
- Bank latch:
  - While phi0 low, bank_q <= (cpu_e ? 8'h00 : cpu_d_in).
  - Holds through PHI2; the value on the last PHI1 edge wins.
- Config register cfg_q[7:0]:
  - Bit 0: HIMEM enable.
  - Bit 1: shadow enable.
  - Bits 3:2: wait states WS (0-3).
  - Bits 7:4: reserved, always read 0.
  - Write qualifier: phi0 high, vda, !rnw, bank_q==0, addr==CFG_ADDR.
  - When qualified, cfg_q[3:0] <= cpu_d_in[3:0] every edge; the last PHI2 edge wins.
- cfg_rd = phi0 & vda & rnw & bank_q==0 & addr==CFG_ADDR (combinational). cfg_rdata = {4'b0, cfg_q[3:0]}.
- Select (combinational from bank_q/addr/cfg_q):
  - hi_sel = cfg_q[0] & bank_q[7:6]==HIMEM_MATCH.
  - sh_sel = cfg_q[1] & !cpu_e & bank_q==0 & !addr[15].
  - sel = (vda|vpa) & (hi_sel|sh_sel); hi_sel takes priority for ram_bank.
- ram_bank:
  - hi_sel: bank_q[RAM_ABITS-17:0].
  - sh_sel: SHADOW_BANK[RAM_ABITS-17:0].
  - otherwise: 0.
- ram_ceb = !(phi0 & sel & !ws_busy). RAM is enabled only in the final (released) PHI2 of a stretched access.
- dummy_access = sel; bbc_rnw = rnw | sel.
- Wait-state FSM, states IDLE and WAIT, counter ws_cnt[1:0]:
  - IDLE: on rise with sel and WS!=0, go to WAIT with ws_cnt=WS and rdy_lo=1. With WS==0, stay in IDLE.
  - WAIT: on each rise, ws_cnt--. When ws_cnt reaches 0 on a rise, go to IDLE and rdy_lo=0 in that same PHI2. The access completes there.
  - ws_busy = (state==WAIT). A config write during WAIT does not alter the current count.
  - Latency: WS extra full 2 MHz cycles; rdy_lo asserted from the ck8 edge after the selecting rise.
- Reset: cfg_q=0, bank_q=0, ph0_q=0, state=IDLE, ws_cnt=0.
  - Resulting outputs: rdy_lo=0, ram_ceb=1, ram_bank=0, dummy_access=0, bbc_rnw=rnw, cfg_rd=0 (bank_q=0 but reset holds phi0 edges irrelevant; cfg_rd follows its equation), cfg_rdata=0.
  - Reset mid-WAIT releases RDY on the next edge.
- Emulation mode: bank_q is always 0, so HIMEM is unreachable unless HIMEM_MATCH==2'b00. Shadowing is disabled.

Test Plan:
- Reset then CPU read 0x8000 in bank 0x00 -> ram_ceb=1, bbc_rnw=1, rdy_lo=0, dummy_access=0.
- Write 0x01 to 0xFCF0 in bank 0, then read bank 0xC5 addr 0x1234, cpu_e=0 -> ram_ceb=0 in PHI2, ram_bank=3'b101, bbc_rnw=1 on a write, dummy_access=1.
- Write 0x0D (HIMEM, WS=3), access bank 0xC0 -> rdy_lo high for exactly 3 phi0 periods; ram_ceb low only in the 4th PHI2; then IDLE.
- Write 0x02, native read bank 0 addr 0x7FFF -> ram_bank=SHADOW_BANK low bits. Same access with cpu_e=1 -> ram_ceb=1.
- Read 0xFCF0 after writing 0xFF -> cfg_rd=1, cfg_rdata=0x0F.
- Assert reset during WAIT (WS=2) -> next edge rdy_lo=0, cfg_rdata=0; a following bank-0xC0 access is not decoded.

Source files
------------

// File: rtl/himem_ctrl_m_if.sv
// CPU-socket / host-bus signal bundle for the 65816 high-memory controller.
// The slave side is the controller itself; the master side is the CPU/host
// environment driving the socket pins.
interface himem_ctrl_m_if #(
    parameter int RAM_ABITS = 19
);
    // Host phase clock and CPU socket inputs
    logic                   bbc_ck2_phi0;
    logic                   cpu_e;
    logic                   vda;
    logic                   vpa;
    logic                   rnw;
    logic [15:0]            addr;
    logic [7:0]             cpu_d_in;

    // Controller outputs towards RAM, host bus and CPU
    logic                   ram_ceb;
    logic [RAM_ABITS-17:0]  ram_bank;
    logic                   bbc_rnw;
    logic                   dummy_access;
    logic                   rdy_lo;
    logic                   cfg_rd;
    logic [7:0]             cfg_rdata;

    modport slave (
        input  bbc_ck2_phi0, cpu_e, vda, vpa, rnw, addr, cpu_d_in,
        output ram_ceb, ram_bank, bbc_rnw, dummy_access, rdy_lo, cfg_rd, cfg_rdata
    );

    modport master (
        output bbc_ck2_phi0, cpu_e, vda, vpa, rnw, addr, cpu_d_in,
        input  ram_ceb, ram_bank, bbc_rnw, dummy_access, rdy_lo, cfg_rd, cfg_rdata
    );
endinterface

// File: rtl/himem_ctrl_m.sv
// 65816 high-memory controller: latches the bank byte, decodes on-board RAM
// (high banks and optional bank-0 low-RAM shadow), turns those accesses into
// dummy host reads, and stretches them with a programmable RDY wait-state
// generator. Everything runs on the host 8 MHz clock.
module himem_ctrl_m #(
    parameter int          RAM_ABITS   = 19,
    parameter logic [1:0]  HIMEM_MATCH = 2'b11,
    parameter logic [15:0] CFG_ADDR    = 16'hFCF0,
    parameter logic [7:0]  SHADOW_BANK = 8'h40
) (
    input  logic            bbc_ck8,
    input  logic            reset,
    himem_ctrl_m_if.slave   bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ws_state_e;

    logic                   ph0_q;
    logic [7:0]             bank_q;
    logic [3:0]             cfg_q;
    ws_state_e              state_q, state_d;
    logic [1:0]             ws_cnt_q, ws_cnt_d;

    logic                   rise;
    logic                   bank0;
    logic                   cfg_hit;
    logic                   hi_sel;
    logic                   sh_sel;
    logic                   sel;
    logic                   ws_start;
    logic                   ws_busy;

    // Start of PHI2, seen one ck8 cycle after phi0 goes high
    assign rise     = bus.bbc_ck2_phi0 & ~ph0_q;
    assign bank0    = (bank_q == 8'h00);
    assign cfg_hit  = bus.bbc_ck2_phi0 & bus.vda & bank0 & (bus.addr == CFG_ADDR);

    assign hi_sel   = cfg_q[0] & (bank_q[7:6] == HIMEM_MATCH);
    assign sh_sel   = cfg_q[1] & ~bus.cpu_e & bank0 & ~bus.addr[15];
    assign sel      = (bus.vda | bus.vpa) & (hi_sel | sh_sel);

    // A stretched access must keep the RAM off in its very first PHI2 cycle
    // too, before the FSM has had an edge to enter WAIT.
    assign ws_start = (state_q == ST_IDLE) & rise & sel & (cfg_q[3:2] != 2'd0);
    assign ws_busy  = (state_q == ST_WAIT) | ws_start;

    assign bus.ram_bank     = hi_sel ? bank_q[RAM_ABITS-17:0]
                            : sh_sel ? SHADOW_BANK[RAM_ABITS-17:0]
                            :          '0;
    assign bus.ram_ceb      = ~(bus.bbc_ck2_phi0 & sel & ~ws_busy);
    assign bus.dummy_access = sel;
    assign bus.bbc_rnw      = bus.rnw | sel;
    assign bus.rdy_lo       = (state_q == ST_WAIT);
    assign bus.cfg_rd       = cfg_hit & bus.rnw;
    assign bus.cfg_rdata    = {4'b0000, cfg_q};

    // Phase edge history, PHI1 bank-byte latch and config register writes
    always_ff @(posedge bbc_ck8) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            ph0_q  <= 1'b0;
            bank_q <= 8'h00;
            cfg_q  <= 4'h0;
        end else begin
            ph0_q <= bus.bbc_ck2_phi0;
            if (!bus.bbc_ck2_phi0) begin
                bank_q <= bus.cpu_e ? 8'h00 : bus.cpu_d_in;
            end
            if (cfg_hit && !bus.rnw) begin
                cfg_q <= bus.cpu_d_in[3:0];
            end
        end
    end

    // Wait-state FSM state and counter registers
    always_ff @(posedge bbc_ck8) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ws_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ws_cnt_q <= ws_cnt_d;
        end
    end

    // Wait-state next-state logic: load WS on a selecting rise, count rises
    always_comb begin
        // NOTE: hold values are assigned first so no path leaves a latch.
        state_d  = state_q;
        ws_cnt_d = ws_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ws_start) begin
                    state_d  = ST_WAIT;
                    ws_cnt_d = cfg_q[3:2];
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    ws_cnt_d = ws_cnt_q - 2'd1;
                    if (ws_cnt_q == 2'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ws_cnt_d = 2'd0;
            end
        endcase
    end

endmodule
